// File: rtl/tarb_pkg.sv
// Shared types and default sizing for the timer arbiter.
package tarb_pkg;

    // One-hot state encoding; any other code is treated as IDLE.
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        ST   = 4'b0010,
        HD   = 4'b0100,
        DT   = 4'b1000
    } state_t;

    localparam int TARB_N_DEF        = 4;
    localparam int TARB_HOLD_MAX_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request bit at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          valid,
    output logic [SW-1:0] idx
);

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                valid = 1'b1;
                idx   = SW'(j);
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner of a single delay timer shared by N requesters.
// Runs RESET -> START -> wait READY -> hold Y for the chosen owner.
// Optional hold-time preemption is enabled by defining TARB_PREEMPT_EN.
module timer_arbiter
    import tarb_pkg::*;
#(
    parameter  int N        = TARB_N_DEF,
    parameter  int HOLD_MAX = TARB_HOLD_MAX_DEF,
    localparam int SW       = $clog2(N)
) (
    input  logic          CLK,
    input  logic          N_RESET,
    input  logic [N-1:0]  X,
    input  logic          READY,
    output logic          RESET,
    output logic          START,
    output logic [N-1:0]  GNT,
    output logic [N-1:0]  Y,
    output logic [SW-1:0] SEL,
    output logic          BUSY
);

    if (N < 2 || HOLD_MAX < 1) begin : g_bad_param
        $error("timer_arbiter: N must be >= 2 and HOLD_MAX >= 1");
    end

    state_t        r_state, w_next;
    logic [SW-1:0] r_owner, r_ptr, w_ptr_nxt, w_pick_idx;
    logic [N-1:0]  w_req, w_owner_oh;
    logic          w_pick_vld, w_own_x, w_release, w_preempt;

    assign w_owner_oh = {{(N-1){1'b0}}, 1'b1} << r_owner;
    assign w_own_x    = X[r_owner];
    assign w_ptr_nxt  = (r_owner == SW'(N - 1)) ? '0 : r_owner + 1'b1;
    assign w_release  = (r_state == HD || r_state == DT) && (w_next == IDLE);

`ifdef TARB_PREEMPT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_mask;

    // A preempted owner stays out of the pick until it drops its request.
    assign w_req     = X & ~r_mask;
    assign w_preempt = (r_state == DT) && w_own_x && (r_cnt == CW'(HOLD_MAX))
                       && (|(X & ~w_owner_oh));

    // DT hold counter (saturating) and preemption mask.
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            r_cnt  <= '0;
            r_mask <= '0;
        end else begin
            if (r_state != DT)
                r_cnt <= '0;
            else if (r_cnt != CW'(HOLD_MAX))
                r_cnt <= r_cnt + 1'b1;
            r_mask <= (r_mask | (w_preempt ? w_owner_oh : '0)) & X;
        end
    end
`else
    assign w_req     = X;
    assign w_preempt = 1'b0;
`endif

    rr_pick #(.N(N), .SW(SW)) u_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .valid (w_pick_vld),
        .idx   (w_pick_idx)
    );

    // Next-state: owner X drop beats READY; illegal codes fall back to IDLE.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE: w_next = w_pick_vld ? ST : IDLE;
            ST:   w_next = HD;
            HD:   w_next = !w_own_x ? IDLE : (READY ? DT : HD);
            DT:   w_next = (!w_own_x || w_preempt) ? IDLE : DT;
            default: w_next = IDLE;
        endcase
    end

    // State, owner latch on pick, and pointer advance on release.
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_pick_vld) r_owner <= w_pick_idx;
            if (w_release)                     r_ptr   <= w_ptr_nxt;
        end
    end

    // Moore outputs from state and owner only; unknown codes decode as IDLE.
    always_comb begin
        RESET = 1'b0;
        START = 1'b0;
        GNT   = '0;
        Y     = '0;
        BUSY  = 1'b0;
        SEL   = r_owner;
        case (r_state)
            ST: begin START = 1'b1; GNT = w_owner_oh; BUSY = 1'b1; end
            HD: begin GNT = w_owner_oh; BUSY = 1'b1; end
            DT: begin GNT = w_owner_oh; Y = w_owner_oh; BUSY = 1'b1; end
            default: RESET = 1'b1;
        endcase
    end

endmodule
